// File: rtl/led_frame_reader.sv
// Read-only Wishbone master that streams a frame of words from memory into a
// first-word-fall-through buffer feeding an LED driver.
// Optional bus timeout/abort logic is enabled by defining LED_READER_TIMEOUT_EN.
module led_frame_reader #(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 32,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic [ADDR_WIDTH-1:0] frame_len,
  output logic                  busy,
  output logic                  frame_done,
  output logic                  bus_error,
  output logic [ADDR_WIDTH-1:0] wbm_address,
  output logic [DATA_WIDTH-1:0] wbm_writedata,
  input  logic [DATA_WIDTH-1:0] wbm_readdata,
  output logic                  wbm_strobe,
  output logic                  wbm_cycle,
  output logic                  wbm_write,
  input  logic                  wbm_ack,
  output logic [DATA_WIDTH-1:0] pix_data,
  output logic                  pix_valid,
  input  logic                  pix_ready
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);

`ifdef LED_READER_TIMEOUT_EN
  typedef enum logic [2:0] {IDLE, CHECK, READ, DONE, ABORT} state_t;
`else
  typedef enum logic [1:0] {IDLE, CHECK, READ, DONE} state_t;
`endif

  state_t                  state_reg, state_next;
  logic [ADDR_WIDTH-1:0]   addr_reg, addr_next;
  logic [ADDR_WIDTH-1:0]   len_reg, len_next;
  logic [ADDR_WIDTH-1:0]   word_cnt_reg, word_cnt_next;
  logic                    push;
  logic                    pop;
  logic                    push_ok;
  logic                    fifo_free;

  logic [DATA_WIDTH-1:0]   fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]        wr_ptr_reg, rd_ptr_reg;
  logic [CNT_W-1:0]        count_reg;

`ifdef LED_READER_TIMEOUT_EN
  logic [7:0]              timer_reg, timer_next;
  logic                    bus_error_reg, bus_error_next;
`endif

  // Only one read is ever outstanding and CHECK is entered after it has been
  // pushed, so the occupancy already includes every reserved slot here.
  assign fifo_free = (count_reg < DEPTH_C);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg    <= IDLE;
      addr_reg     <= '0;
      len_reg      <= '0;
      word_cnt_reg <= '0;
    end else begin
      state_reg    <= state_next;
      addr_reg     <= addr_next;
      len_reg      <= len_next;
      word_cnt_reg <= word_cnt_next;
    end
  end

  always_comb begin
    state_next    = state_reg;
    addr_next     = addr_reg;
    len_next      = len_reg;
    word_cnt_next = word_cnt_reg;
    push          = 1'b0;
`ifdef LED_READER_TIMEOUT_EN
    timer_next     = timer_reg;
    bus_error_next = bus_error_reg;
`endif
    case (state_reg)
      IDLE: begin
        if (start) begin
          addr_next     = base_addr;
          len_next      = frame_len;
          word_cnt_next = '0;
          state_next    = CHECK;
`ifdef LED_READER_TIMEOUT_EN
          bus_error_next = 1'b0;
`endif
        end
      end
      CHECK: begin
        if (word_cnt_reg == len_reg) begin
          state_next = DONE;
        end else if (fifo_free) begin
          state_next = READ;
`ifdef LED_READER_TIMEOUT_EN
          timer_next = '0;
`endif
        end
      end
      READ: begin
        if (wbm_ack) begin
          push          = 1'b1;
          addr_next     = addr_reg + 1'b1;
          word_cnt_next = word_cnt_reg + 1'b1;
          state_next    = CHECK;
        end
`ifdef LED_READER_TIMEOUT_EN
        // The 256th unacknowledged cycle is the last one the strobe is held.
        else if (timer_reg == 8'd255) begin
          bus_error_next = 1'b1;
          state_next     = ABORT;
        end else begin
          timer_next = timer_reg + 1'b1;
        end
`endif
      end
      DONE: state_next = IDLE;
`ifdef LED_READER_TIMEOUT_EN
      ABORT: state_next = IDLE;
`endif
      default: state_next = IDLE;
    endcase
  end

`ifdef LED_READER_TIMEOUT_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      timer_reg     <= '0;
      bus_error_reg <= 1'b0;
    end else begin
      timer_reg     <= timer_next;
      bus_error_reg <= bus_error_next;
    end
  end
  assign bus_error = bus_error_reg;
`else
  assign bus_error = 1'b0;
`endif

  assign pop     = pix_valid && pix_ready;
  assign push_ok = push && ((count_reg != DEPTH_C) || pop);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push_ok) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (pop)     rd_ptr_reg <= rd_ptr_reg + 1'b1;
      case ({push_ok, pop})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase
    end
  end

  // Storage is left unreset; the output mux hides stale contents.
  always_ff @(posedge clk) begin
    if (push_ok) fifo_mem[wr_ptr_reg] <= wbm_readdata;
  end

  assign pix_valid = (count_reg != '0);
  assign pix_data  = pix_valid ? fifo_mem[rd_ptr_reg] : '0;

  assign busy          = (state_reg == CHECK) || (state_reg == READ);
  assign frame_done    = (state_reg == DONE);
  assign wbm_cycle     = (state_reg == READ);
  assign wbm_strobe    = (state_reg == READ);
  assign wbm_address   = addr_reg;
  assign wbm_write     = 1'b0;
  assign wbm_writedata = '0;

endmodule

// File: tb/tb_led_frame_reader.sv
// Directed bench for led_frame_reader with a registered-ack memory slave
// whose word at address a holds FFFFFFFF - a.
module tb_led_frame_reader;
  localparam int AW = 16;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic [AW-1:0] base_addr;
  logic [AW-1:0] frame_len;
  logic          busy, frame_done, bus_error;
  logic [AW-1:0] wbm_address;
  logic [DW-1:0] wbm_writedata, wbm_readdata;
  logic          wbm_strobe, wbm_cycle, wbm_write, wbm_ack;
  logic [DW-1:0] pix_data;
  logic          pix_valid, pix_ready;
  logic          ack_en;

  int errors = 0;
  int checks = 0;
  int done_cnt = 0;
  int stb_cnt = 0;
  int wr_seen = 0;
  logic [DW-1:0] pix_q[$];
  logic [AW-1:0] addr_q[$];

  led_frame_reader #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .FIFO_DEPTH(4)) dut (
    .clk(clk), .reset(reset), .start(start), .base_addr(base_addr),
    .frame_len(frame_len), .busy(busy), .frame_done(frame_done),
    .bus_error(bus_error), .wbm_address(wbm_address),
    .wbm_writedata(wbm_writedata), .wbm_readdata(wbm_readdata),
    .wbm_strobe(wbm_strobe), .wbm_cycle(wbm_cycle), .wbm_write(wbm_write),
    .wbm_ack(wbm_ack), .pix_data(pix_data), .pix_valid(pix_valid),
    .pix_ready(pix_ready)
  );

  always #5 clk = ~clk;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      wbm_ack      <= 1'b0;
      wbm_readdata <= '0;
    end else begin
      wbm_ack      <= ack_en && wbm_cycle && wbm_strobe && !wbm_ack;
      wbm_readdata <= 32'hFFFF_FFFF - {16'h0000, wbm_address};
    end
  end

  always @(posedge clk) begin
    if (!reset) begin
      if (pix_valid && pix_ready) pix_q.push_back(pix_data);
      if (wbm_ack && wbm_cycle && wbm_strobe) addr_q.push_back(wbm_address);
      if (frame_done) done_cnt <= done_cnt + 1;
      if (wbm_strobe) stb_cnt <= stb_cnt + 1;
      if (wbm_write || (wbm_writedata != '0)) wr_seen <= wr_seen + 1;
    end
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic pulse_start(input logic [AW-1:0] b, input logic [AW-1:0] l);
    base_addr = b;
    frame_len = l;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int max_cycles);
    int n;
    n = 0;
    while (!frame_done && n < max_cycles) begin
      tick();
      n++;
    end
    check(tag, {31'b0, frame_done}, 32'd1);
  endtask

  task automatic check_pixels(input string tag, input int p0, input logic [AW-1:0] b, input int n);
    logic [DW-1:0] got;
    check({tag, "_count"}, pix_q.size() - p0, n);
    for (int i = 0; i < n; i++) begin
      got = (p0 + i < pix_q.size()) ? pix_q[p0 + i] : 32'hDEAD_BEEF;
      check($sformatf("%s_pix%0d", tag, i), got, 32'hFFFF_FFFF - {16'h0000, AW'(b + AW'(i))});
    end
  endtask

  initial begin
    int p0, a0, d0, s0, n;
    logic [AW-1:0] exp_a [4];

    reset = 1'b1; start = 1'b0; base_addr = '0; frame_len = '0;
    pix_ready = 1'b0; ack_en = 1'b1;
    repeat (3) tick();
    check("rst_busy", busy, 0);
    check("rst_frame_done", frame_done, 0);
    check("rst_bus_error", bus_error, 0);
    check("rst_cycle", wbm_cycle, 0);
    check("rst_strobe", wbm_strobe, 0);
    check("rst_write", wbm_write, 0);
    check("rst_address", wbm_address, 0);
    check("rst_writedata", wbm_writedata, 0);
    check("rst_pix_valid", pix_valid, 0);
    check("rst_pix_data", pix_data, 0);
    reset = 1'b0;
    tick();

    // 8-word frame from address 0, driver always ready
    p0 = pix_q.size(); d0 = done_cnt;
    pix_ready = 1'b1;
    pulse_start(16'h0000, 16'd8);
    $display("txn: start base=0000 len=8");
    check("a_busy_next_cycle", busy, 1);
    check("a_no_strobe_cycle1", wbm_strobe, 0);
    tick();
    check("a_strobe_cycle2", wbm_strobe, 1);
    check("a_cycle_cycle2", wbm_cycle, 1);
    check("a_first_address", wbm_address, 16'h0000);
    n = 0;
    while (!wbm_ack && n < 20) begin tick(); n++; end
    check("a_ack_seen", wbm_ack, 1);
    tick();
    check("a_pix_valid_after_ack", pix_valid, 1);
    check("a_pix_first", pix_data, 32'hFFFF_FFFF);
    wait_done("a_done", 200);
    check("a_busy_at_done", busy, 0);
    tick();
    check("a_done_one_cycle", frame_done, 0);
    repeat (5) tick();
    check("a_done_count", done_cnt - d0, 1);
    check_pixels("a", p0, 16'h0000, 8);

    // zero-length frame
    s0 = stb_cnt; d0 = done_cnt;
    pulse_start(16'h0010, 16'd0);
    $display("txn: start base=0010 len=0");
    check("b_busy", busy, 1);
    check("b_done_not_yet", frame_done, 0);
    tick();
    check("b_done_at_2", frame_done, 1);
    check("b_busy_at_done", busy, 0);
    tick();
    check("b_done_cleared", frame_done, 0);
    check("b_no_strobe", stb_cnt - s0, 0);
    check("b_done_count", done_cnt - d0, 1);

    // backpressure: 10 words with the driver stalled
    p0 = pix_q.size(); a0 = addr_q.size();
    pix_ready = 1'b0;
    pulse_start(16'h0100, 16'd10);
    $display("txn: start base=0100 len=10 stalled");
    repeat (60) tick();
    check("c_reads_while_stalled", addr_q.size() - a0, 4);
    check("c_busy_stalled", busy, 1);
    check("c_strobe_stalled", wbm_strobe, 0);
    check("c_pix_valid_stalled", pix_valid, 1);
    check("c_pix_head", pix_data, 32'hFFFF_FEFF);
    pix_ready = 1'b1;
    wait_done("c_done", 300);
    repeat (6) tick();
    check_pixels("c", p0, 16'h0100, 10);

    // address wrap
    p0 = pix_q.size(); a0 = addr_q.size();
    pulse_start(16'hFFFE, 16'd4);
    $display("txn: start base=FFFE len=4");
    wait_done("d_done", 200);
    repeat (4) tick();
    exp_a[0] = 16'hFFFE; exp_a[1] = 16'hFFFF; exp_a[2] = 16'h0000; exp_a[3] = 16'h0001;
    check("d_addr_count", addr_q.size() - a0, 4);
    for (int i = 0; i < 4; i++)
      check($sformatf("d_addr%0d", i),
            (a0 + i < addr_q.size()) ? addr_q[a0 + i] : 16'hDEAD, exp_a[i]);
    check_pixels("d", p0, 16'hFFFE, 4);

    // reset in the middle of word 3
    a0 = addr_q.size(); d0 = done_cnt;
    pulse_start(16'h0000, 16'd8);
    $display("txn: start base=0000 len=8 then reset");
    n = 0;
    while (!((addr_q.size() - a0) >= 2 && wbm_strobe) && n < 100) begin tick(); n++; end
    check("e_reached_word3", wbm_strobe, 1);
    #2 reset = 1'b1;
    #1;
    check("e_rst_busy", busy, 0);
    check("e_rst_strobe", wbm_strobe, 0);
    check("e_rst_cycle", wbm_cycle, 0);
    check("e_rst_address", wbm_address, 0);
    check("e_rst_pix_valid", pix_valid, 0);
    check("e_rst_pix_data", pix_data, 0);
    check("e_rst_frame_done", frame_done, 0);
    repeat (2) tick();
    reset = 1'b0;
    tick();
    check("e_no_done", done_cnt - d0, 0);
    p0 = pix_q.size();
    pulse_start(16'h0020, 16'd3);
    $display("txn: start base=0020 len=3 after reset");
    wait_done("e_done", 200);
    repeat (4) tick();
    check_pixels("e", p0, 16'h0020, 3);

`ifdef LED_READER_TIMEOUT_EN
    // slave never acknowledges
    d0 = done_cnt;
    ack_en = 1'b0;
    pulse_start(16'h0040, 16'd2);
    $display("txn: start base=0040 len=2 no ack");
    tick();
    n = 0;
    while (wbm_strobe && n < 400) begin n++; tick(); end
    check("f_strobe_cycles", n, 256);
    check("f_bus_error", bus_error, 1);
    check("f_busy", busy, 0);
    check("f_no_done_now", frame_done, 0);
    tick();
    check("f_error_sticky", bus_error, 1);
    check("f_no_done", done_cnt - d0, 0);
    ack_en = 1'b1;
    pulse_start(16'h0000, 16'd0);
    check("f_error_cleared", bus_error, 0);
    repeat (3) tick();
`else
    check("f_bus_error_tied", bus_error, 0);
`endif

    check("never_wrote", wr_seen, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/led_frame_reader.md
LED_FRAME_READER -- requirements
Module: led_frame_reader

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 16, Wishbone word-address width.
REQ-002 SHALL have parameter DATA_WIDTH, default 32, Wishbone and pixel data width.
REQ-003 SHALL have parameter FIFO_DEPTH, default 4, output buffer depth in words (power of two, at least 2).
REQ-004 SHALL have ports:
- clk  in  1  sole clock, all logic on rising edge.
- reset  in  1  asynchronous, active-high.
- start  in  1  one-cycle frame request.
- base_addr  in  ADDR_WIDTH  first word address, sampled on accepted start.
- frame_len  in  ADDR_WIDTH  word count, sampled on accepted start.
- busy  out  1  frame in progress.
- frame_done  out  1  one-cycle completion pulse.
- bus_error  out  1  sticky timeout flag.
- wbm_address  out  ADDR_WIDTH  Wishbone address.
- wbm_writedata  out  DATA_WIDTH  Wishbone write data.
- wbm_readdata  in  DATA_WIDTH  Wishbone read data.
- wbm_strobe  out  1  Wishbone strobe.
- wbm_cycle  out  1  Wishbone cycle.
- wbm_write  out  1  Wishbone write enable.
- wbm_ack  in  1  Wishbone acknowledge.
- pix_data  out  DATA_WIDTH  word to LED driver.
- pix_valid  out  1  pix_data valid.
- pix_ready  in  1  LED driver accepts.

Function
REQ-005 SHALL be a read-only Wishbone master feeding the mem slave: wbm_write and wbm_writedata held 0 always.
REQ-006 SHALL have states IDLE, CHECK, READ, DONE (plus ABORT, see Configuration).
REQ-007 SHALL, in IDLE with start=1: latch base_addr/frame_len, clear word counter, go CHECK, assert busy from the next cycle.
REQ-008 SHALL ignore start while not in IDLE.
REQ-009 SHALL, in CHECK: go DONE if words read == latched length (covers frame_len=0); else go READ if the FIFO has a free slot, counting reserved-but-unwritten entries; else stay in CHECK.
REQ-010 SHALL, in READ, assert wbm_cycle=wbm_strobe=1 with a stable wbm_address until wbm_ack=1, one transaction outstanding at most.
REQ-011 SHALL, on the wbm_ack cycle: write wbm_readdata into the FIFO, increment address modulo 2^ADDR_WIDTH, increment the word counter, drop cycle/strobe next cycle, and go CHECK.
REQ-012 SHALL, in DONE: pulse frame_done for exactly one cycle, deassert busy, and return to IDLE; must not wait for the FIFO to drain.
REQ-013 SHALL present FIFO head on pix_data with pix_valid=1 whenever the FIFO is non-empty; a word transfers on pix_valid and pix_ready both high.
REQ-014 SHALL keep the FIFO first-word-fall-through, with a simultaneous push and pop on a full or empty FIFO handled correctly: no loss, no duplication, count unchanged.
REQ-015 SHALL never overflow the FIFO; pix_ready held low stalls the bus side in CHECK.
REQ-016 SHALL give a minimum latency of 2 cycles from start to first wbm_strobe, and 1 cycle from wbm_ack to pix_valid.

Reset
REQ-017 SHALL, on reset, asynchronously force: state IDLE, busy=0, frame_done=0, bus_error=0, wbm_cycle=0, wbm_strobe=0, wbm_write=0, wbm_address=0, wbm_writedata=0, pix_valid=0, pix_data=0, FIFO empty, counters 0.
REQ-018 SHALL abandon any in-flight transaction and FIFO contents when reset is asserted mid-frame, without emitting frame_done.

Configuration
REQ-019 SHALL, with macro LED_READER_TIMEOUT_EN defined: count READ cycles without ack; at 256 cycles, drop cycle/strobe, set bus_error (sticky until reset or next accepted start), go ABORT, then IDLE next cycle without frame_done.
REQ-020 SHALL, without LED_READER_TIMEOUT_EN: contain no timeout counter and no ABORT state, wait indefinitely for ack, and tie bus_error to 0.

Verification
REQ-021 SHALL cover: base_addr=0, frame_len=8, mem preloaded with FFFFFFFF-addr, pix_ready=1 -> pix_data FFFFFFFF..FFFFFFF8 in order, then one frame_done pulse.
REQ-022 SHALL cover: frame_len=0 -> frame_done 2 cycles after start, no wbm_strobe ever.
REQ-023 SHALL cover: frame_len=10, pix_ready=0 -> exactly FIFO_DEPTH=4 reads then stall in CHECK; pix_ready=1 -> remaining 6 delivered, no loss.
REQ-024 SHALL cover: base_addr=FFFE, frame_len=4 -> addresses FFFE, FFFF, 0000, 0001.
REQ-025 SHALL cover: reset asserted on word 3 of an 8-word frame -> outputs at reset values immediately; a new start then reads correctly.
REQ-026 SHALL cover, with LED_READER_TIMEOUT_EN: slave never acks -> strobe drops after 256 cycles, bus_error=1, busy=0, no frame_done.
